spi_sram_ctrl: RTL and testbench
================================

Name: spi_sram_ctrl

Overview:
SPI master that sequences single-byte READ (0x03) and WRITE (0x02) transactions to the external 64 KB SPI SRAM on behalf of the Neander core's memory interface. It accepts a parallel request (address, write flag, data) and serialises it as a 32-bit frame: 8-bit command, 16-bit address, 8-bit data. It drives the SRAM in SPI mode 0 (SCLK idles low, MOSI launched on falling edge, MISO sampled on rising edge) and returns read data with a one-cycle ready pulse.

Parameters:
CLK_DIV, 1, SCLK half-period in clk cycles (>=1); SCLK = clk/(2*CLK_DIV)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
mem_req  in  1  request; sampled only when idle
mem_we  in  1  1=write, 0=read; latched with mem_req
mem_addr  in  16  byte address; latched with mem_req
mem_wdata  in  8  write data; latched with mem_req
mem_rdata  out  8  read data; valid from the mem_ready cycle, held until next read completes
mem_ready  out  1  one-cycle completion pulse
mem_busy  out  1  high from the acceptance edge until the ready pulse (inclusive)
spi_cs_n  out  1  SRAM chip select, active low
spi_sclk  out  1  SPI clock
spi_mosi  out  1  SPI data to SRAM
spi_miso  in  1  SPI data from SRAM

Behaviour:
- One clock domain. Reset is asynchronous and active-high (rst), clocked on clk. Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, mem_ready=0, mem_busy=0, mem_rdata=8'h00, state=IDLE.
- FSM states:
  - IDLE -> SHIFT on a clk edge with mem_req=1. That edge latches we/addr/wdata, loads frame {cmd, addr, wdata or 8'h00}, sets spi_cs_n=0, spi_mosi=frame[31], mem_busy=1.
  - SHIFT: a divider counts CLK_DIV cycles per half-phase. 64 half-phases run, alternating rise/fall.
    - Rising edge k (k=1..32): spi_sclk<=1, and spi_miso is captured into rx shift register (rx <= {rx[6:0], spi_miso}). Only k=25..32 are meaningful.
    - Falling edge: spi_sclk<=0, and spi_mosi<=next frame bit. The final falling edge (k=32) leaves spi_mosi=0 and moves to DONE.
  - DONE (1 cycle): spi_cs_n<=1, mem_ready<=1 (pulse), mem_busy deasserts the following cycle. On reads, mem_rdata<=rx. On writes, mem_rdata is unchanged. Next state is IDLE.
- Latency: the ready pulse is registered 64*CLK_DIV+1 clk edges after the acceptance edge. Minimum spi_cs_n high time between frames is 1 clk (the IDLE cycle). Back-to-back throughput is 64*CLK_DIV+2 cycles per access.
- mem_req while not IDLE is ignored and not queued. The requester holds mem_req until mem_ready, or re-issues it. Latched operands make changes to mem_addr/wdata during a transaction irrelevant.
- mem_req high in the DONE cycle is not accepted. Acceptance occurs in IDLE on the next cycle.
- Address wrap: none needed; the full 16-bit space is sent verbatim.
- rst asserted mid-frame: immediate cs_n=1, sclk=0, which aborts the SRAM transaction. A partial write does not commit. There is no ready pulse.

Optional Feature:
SPI_SRAM_CTRL_LAST_BYTE_CACHE_EN
- Defined: adds a single-entry tag/data/valid register.
  - A read whose address matches a valid tag completes without any SPI activity: mem_ready pulses on the edge after acceptance, mem_rdata=cached data, and spi_cs_n stays 1.
  - Every completed read or write (SPI) loads the tag and data.
  - Reset clears valid.
- Undefined: every access performs a full SPI frame. There is no cache logic.

Decomposition:
- Package spi_sram_pkg holds:
  - SPI_CMD_READ=8'h03
  - SPI_CMD_WRITE=8'h02
  - SPI_FRAME_BITS=32
  - the state enum type (IDLE, SHIFT, DONE)
- One sub-module spi_sram_clk_div: counter producing a one-cycle tick every CLK_DIV cycles while enabled. It is cleared on enable deassert.
- The shift/FSM logic stays in spi_sram_ctrl.

Test Plan:
- CLK_DIV=1, write addr=16'h1234 data=8'hA5 -> MOSI frame 0x021234A5 MSB-first on 32 rising edges; ready exactly 65 cycles after acceptance; model read_byte(16'h1234)==8'hA5.
- Preload model 16'h00FF=8'h80, read 16'h00FF -> frame 0x0300FF00; mem_rdata=8'h80 at ready; cs_n high 1 cycle before next frame.
- CLK_DIV=3, read preloaded 16'hFFFF=8'h5A -> SCLK high/low 3 cycles each; ready 193 cycles after acceptance; rdata 8'h5A.
- Hold mem_req high continuously with changing addr during busy -> exactly one frame per 66 cycles (CLK_DIV=1); each frame uses the address present at its acceptance edge.
- Assert rst at rising edge 20 of a write of 8'h33 to 16'h0010 -> cs_n=1 and sclk=0 immediately, no ready; memory[16'h0010] unchanged (8'h00); subsequent read works.
- With SPI_SRAM_CTRL_LAST_BYTE_CACHE_EN: write 16'h0042=8'h7E then read 16'h0042 -> ready 1 cycle after acceptance, cs_n never falls, rdata 8'h7E. Without the macro the same read takes 65 cycles.

Source files
------------

// File: rtl/spi_sram_pkg.sv
// Shared constants, FSM state type and frame builder for the SPI SRAM controller.
package spi_sram_pkg;

    localparam logic [7:0] SPI_CMD_READ   = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
    localparam int         SPI_FRAME_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    // Reads carry a zero data byte; the SRAM drives MISO during that slot.
    function automatic logic [31:0] build_frame(input logic       we,
                                                input logic [15:0] addr,
                                                input logic [7:0]  wdata);
        logic [7:0] cmd;
        logic [7:0] data;
        if (we) begin
            cmd  = SPI_CMD_WRITE;
            data = wdata;
        end else begin
            cmd  = SPI_CMD_READ;
            data = 8'h00;
        end
        return {cmd, addr, data};
    endfunction

endpackage

// File: rtl/spi_sram_clk_div.sv
// Half-phase tick generator: one-cycle tick every CLK_DIV clk cycles while en is high.
module spi_sram_clk_div #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          at_end_s;

    assign at_end_s = (cnt_r == CW'(CLK_DIV - 1));
    assign tick     = en & at_end_s;

    // Counter restarts from zero whenever the divider is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!en || at_end_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/spi_sram_ctrl.sv
// SPI mode-0 master issuing single-byte READ/WRITE frames to a 64 KB SPI SRAM.
// Optional single-entry read cache enabled by defining SPI_SRAM_CTRL_LAST_BYTE_CACHE_EN.
module spi_sram_ctrl
    import spi_sram_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam logic [5:0] LAST_PHASE = 6'(2 * SPI_FRAME_BITS - 1);

    spi_state_e  state_r;
    logic [31:0] frame_r;
    logic [5:0]  phase_r;
    logic [7:0]  rx_r;
    logic        we_r;
    logic        tick_s;
    logic        shift_en_s;
    logic        start_spi_s;
    logic [7:0]  rd_src_s;
    logic [31:0] start_frame_s;

    assign shift_en_s    = (state_r == SHIFT);
    assign start_frame_s = build_frame(mem_we, mem_addr, mem_wdata);

    spi_sram_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk (clk),
        .rst (rst),
        .en  (shift_en_s),
        .tick(tick_s)
    );

`ifdef SPI_SRAM_CTRL_LAST_BYTE_CACHE_EN
    logic        cache_valid_r;
    logic [15:0] cache_tag_r;
    logic [7:0]  cache_data_r;
    logic [15:0] pend_addr_r;
    logic [7:0]  pend_wdata_r;
    logic        hit_r;
    logic        hit_s;

    assign hit_s       = mem_req & ~mem_we & cache_valid_r & (cache_tag_r == mem_addr);
    assign start_spi_s = mem_req & ~hit_s;
    assign rd_src_s    = hit_r ? cache_data_r : rx_r;

    // Tag/data capture: operands latched at acceptance, entry refreshed after each SPI frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_r <= 1'b0;
            cache_tag_r   <= 16'h0000;
            cache_data_r  <= 8'h00;
            pend_addr_r   <= 16'h0000;
            pend_wdata_r  <= 8'h00;
            hit_r         <= 1'b0;
        end else if (state_r == IDLE && mem_req) begin
            hit_r        <= hit_s;
            pend_addr_r  <= mem_addr;
            pend_wdata_r <= mem_wdata;
        end else if (state_r == DONE && !hit_r) begin
            cache_valid_r <= 1'b1;
            cache_tag_r   <= pend_addr_r;
            cache_data_r  <= we_r ? pend_wdata_r : rx_r;
        end
    end
`else
    assign start_spi_s = mem_req;
    assign rd_src_s    = rx_r;
`endif

    // Transaction FSM: all SPI pins and requester handshakes are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            frame_r   <= 32'h0000_0000;
            phase_r   <= 6'd0;
            rx_r      <= 8'h00;
            we_r      <= 1'b0;
            mem_rdata <= 8'h00;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            spi_cs_n  <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mem_ready <= 1'b0;
                    mem_busy  <= mem_req;
                    we_r      <= mem_req ? mem_we : we_r;
                    if (start_spi_s) begin
                        frame_r  <= start_frame_s;
                        phase_r  <= 6'd0;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= start_frame_s[31];
                        state_r  <= SHIFT;
                    end else if (mem_req) begin
                        // Only reachable on a cache hit: skip the bus entirely.
                        state_r <= DONE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        phase_r <= phase_r + 6'd1;
                        if (!phase_r[0]) begin
                            spi_sclk <= 1'b1;
                            rx_r     <= {rx_r[6:0], spi_miso};
                        end else begin
                            spi_sclk <= 1'b0;
                            frame_r  <= {frame_r[30:0], 1'b0};
                            if (phase_r == LAST_PHASE) begin
                                spi_mosi <= 1'b0;
                                state_r  <= DONE;
                            end else begin
                                spi_mosi <= frame_r[30];
                            end
                        end
                    end
                end
                DONE: begin
                    spi_cs_n  <= 1'b1;
                    mem_ready <= 1'b1;
                    if (!we_r) begin
                        mem_rdata <= rd_src_s;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    spi_cs_n  <= 1'b1;
                    spi_sclk  <= 1'b0;
                    spi_mosi  <= 1'b0;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Directed bench for spi_sram_ctrl: instance 0 uses CLK_DIV=1, instance 1 uses CLK_DIV=3,
// each attached to a behavioural SPI SRAM.
module tb_spi_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we  = 2'b00;
    logic [15:0] addr  [2];
    logic [7:0]  wdata [2];
    logic [7:0]  rdata [2];
    logic [1:0]  ready, busy, cs_n, sclk, mosi, miso;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] preload(input logic [15:0] a);
        case (a)
            16'h00FF: return 8'h80;
            16'hFFFF: return 8'h5A;
            default:  return 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        spi_sram_ctrl #(
            .CLK_DIV(g == 0 ? 1 : 3)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .mem_req  (req[g]),
            .mem_we   (we[g]),
            .mem_addr (addr[g]),
            .mem_wdata(wdata[g]),
            .mem_rdata(rdata[g]),
            .mem_ready(ready[g]),
            .mem_busy (busy[g]),
            .spi_cs_n (cs_n[g]),
            .spi_sclk (sclk[g]),
            .spi_mosi (mosi[g]),
            .spi_miso (miso[g])
        );

        logic [7:0]  mem [logic [15:0]];
        logic [31:0] sh = 32'h0;
        logic [31:0] last_frame = 32'h0;
        int          bits = 0;
        int          last_bits = 0;
        int          frames = 0;
        int          commits = 0;
        int          cs_falls = 0;
        logic [7:0]  rd_byte = 8'h00;
        logic        rd_active = 1'b0;
        logic        miso_r = 1'b1;

        assign miso[g] = miso_r;

        always @(negedge cs_n[g]) cs_falls++;

        always @(posedge sclk[g] or posedge cs_n[g]) begin
            if (cs_n[g]) begin
                if (bits > 0) begin
                    last_frame = sh;
                    last_bits  = bits;
                    frames++;
                    if (bits == 32 && sh[31:24] == 8'h02) begin
                        mem[sh[23:8]] = sh[7:0];
                        commits++;
                    end
                end
                bits = 0;
                sh   = 32'h0;
            end else begin
                sh = {sh[30:0], mosi[g]};
                bits++;
            end
        end

        always @(negedge sclk[g]) begin
            if (!cs_n[g] && bits == 24 && sh[23:16] == 8'h03) begin
                rd_byte   = mem.exists(sh[15:0]) ? mem[sh[15:0]] : preload(sh[15:0]);
                rd_active = 1'b1;
                miso_r    = rd_byte[7];
            end else if (!cs_n[g] && rd_active && bits > 24 && bits < 32) begin
                miso_r = rd_byte[31 - bits];
            end else begin
                rd_active = 1'b0;
                miso_r    = 1'b1;
            end
        end
    end

    task automatic do_access(input int i, input logic w, input logic [15:0] a, input logic [7:0] d,
                             output int lat, output logic acc_busy, output logic [7:0] rd);
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        acc_busy = busy[i];
        req[i] = 1'b0; addr[i] = ~a; wdata[i] = ~d;
        lat = -1;
        rd  = 8'hxx;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (ready[i]) begin
                lat = n;
                rd  = rdata[i];
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 2'b00; we = 2'b00;
        addr[0] = 16'h0; addr[1] = 16'h0; wdata[0] = 8'h0; wdata[1] = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({cs_n[i], sclk[i], mosi[i], ready[i], busy[i], rdata[i]} !== {5'b10000, 8'h00}) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got %b_%h expected 10000_00", i,
                         {cs_n[i], sclk[i], mosi[i], ready[i], busy[i]}, rdata[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write;
        int lat; logic ab; logic [7:0] rd;
        do_access(0, 1'b1, 16'h1234, 8'hA5, lat, ab, rd);
        n_cmp++; if (ab !== 1'b1) begin n_bad++; $display("FAIL wr_busy_at_accept: got %b expected 1", ab); end
        n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL wr_latency: got %0d expected 65", lat); end
        n_cmp++; if (g_inst[0].last_frame !== 32'h021234A5) begin
            n_bad++; $display("FAIL wr_frame: got %h expected 021234a5", g_inst[0].last_frame); end
        n_cmp++; if (g_inst[0].last_bits !== 32) begin
            n_bad++; $display("FAIL wr_bits: got %0d expected 32", g_inst[0].last_bits); end
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL wr_rdata_held: got %h expected 00", rd); end
        n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL wr_busy_at_ready: got %b expected 1", busy[0]); end
        @(posedge clk); #1;
        n_cmp++; if ({ready[0], busy[0], cs_n[0]} !== 3'b001) begin
            n_bad++; $display("FAIL wr_after_ready: got %b expected 001", {ready[0], busy[0], cs_n[0]}); end
    endtask

    task automatic test_read;
        int lat; logic ab; logic [7:0] rd;
        do_access(0, 1'b0, 16'h00FF, 8'hCC, lat, ab, rd);
        n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL rd_latency: got %0d expected 65", lat); end
        n_cmp++; if (g_inst[0].last_frame !== 32'h0300FF00) begin
            n_bad++; $display("FAIL rd_frame: got %h expected 0300ff00", g_inst[0].last_frame); end
        n_cmp++; if (rd !== 8'h80) begin n_bad++; $display("FAIL rd_data: got %h expected 80", rd); end
    endtask

    task automatic test_back_to_back;
        int accs = 0, readies = 0, prev_acc = -1, gap_bad = 0, addr_bad = 0;
        logic prev_cs;
        logic [15:0] acc_addr = 16'h0;
        prev_cs = cs_n[0];
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h4000;
        for (int n = 1; n <= 400 && readies < 3; n++) begin
            @(posedge clk); #1;
            if (prev_cs && !cs_n[0]) begin
                accs++;
                if (prev_acc >= 0 && n - prev_acc != 66) gap_bad++;
                prev_acc = n;
                acc_addr = addr[0];
            end
            if (ready[0]) begin
                readies++;
                if (g_inst[0].last_frame !== {8'h03, acc_addr, 8'h00}) addr_bad++;
            end
            prev_cs = cs_n[0];
            if (readies == 3) req[0] = 1'b0;
            @(negedge clk);
            addr[0] = 16'h4000 + 16'(n);
        end
        req[0] = 1'b0;
        n_cmp++; if (accs !== 3) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 3", accs); end
        n_cmp++; if (readies !== 3) begin n_bad++; $display("FAIL b2b_readies: got %0d expected 3", readies); end
        n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL b2b_period: got %0d bad gaps expected 0", gap_bad); end
        n_cmp++; if (addr_bad !== 0) begin n_bad++; $display("FAIL b2b_addr: got %0d bad frames expected 0", addr_bad); end
    endtask

    task automatic test_clk_div3;
        int lat = -1, run = 1, hi_runs = 0, lo_runs = 0, bad = 0;
        logic lvl, seen_hi = 1'b0;
        logic [7:0] rd = 8'hxx;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'hFFFF; wdata[1] = 8'h00;
        @(posedge clk); #1;
        req[1] = 1'b0;
        lvl = sclk[1];
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (ready[1]) begin lat = n; rd = rdata[1]; break; end
            if (sclk[1] === lvl) begin
                run++;
            end else begin
                if (lvl) begin
                    hi_runs++; seen_hi = 1'b1;
                    if (run != 3) bad++;
                end else if (seen_hi) begin
                    lo_runs++;
                    if (run != 3) bad++;
                end
                lvl = sclk[1];
                run = 1;
            end
        end
        n_cmp++; if (lat !== 193) begin n_bad++; $display("FAIL div3_latency: got %0d expected 193", lat); end
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL div3_rdata: got %h expected 5a", rd); end
        n_cmp++; if (hi_runs !== 32 || lo_runs !== 31 || bad !== 0) begin
            n_bad++; $display("FAIL div3_sclk: got hi=%0d lo=%0d bad=%0d expected 32/31/0", hi_runs, lo_runs, bad); end
        n_cmp++; if (g_inst[1].last_frame !== 32'h03FFFF00) begin
            n_bad++; $display("FAIL div3_frame: got %h expected 03ffff00", g_inst[1].last_frame); end
    endtask

    task automatic test_reset_abort;
        int rises = 0, lat, commits0;
        logic prev = 1'b0, seen_ready = 1'b0, ab;
        logic [7:0] rd;
        commits0 = g_inst[0].commits;
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 8'h33;
        @(posedge clk); #1;
        req[0] = 1'b0;
        for (int n = 1; n <= 200 && rises < 20; n++) begin
            @(posedge clk); #1;
            if (ready[0]) seen_ready = 1'b1;
            if (sclk[0] && !prev) rises++;
            prev = sclk[0];
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (rises !== 20) begin n_bad++; $display("FAIL abort_rises: got %0d expected 20", rises); end
        n_cmp++; if ({cs_n[0], sclk[0]} !== 2'b10) begin
            n_bad++; $display("FAIL abort_pins: got %b expected 10", {cs_n[0], sclk[0]}); end
        repeat (3) begin
            @(posedge clk); #1;
            if (ready[0]) seen_ready = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL abort_no_ready: got %b expected 0", seen_ready); end
        n_cmp++; if (g_inst[0].commits !== commits0 || g_inst[0].last_bits !== 20) begin
            n_bad++; $display("FAIL abort_no_commit: got commits=%0d bits=%0d expected %0d/20",
                              g_inst[0].commits, g_inst[0].last_bits, commits0); end
        do_access(0, 1'b0, 16'h0010, 8'h00, lat, ab, rd);
        n_cmp++; if (lat !== 65 || rd !== 8'h00) begin
            n_bad++; $display("FAIL abort_readback: got lat=%0d data=%h expected 65/00", lat, rd); end
        do_access(0, 1'b0, 16'h1234, 8'h00, lat, ab, rd);
        n_cmp++; if (lat !== 65 || rd !== 8'hA5) begin
            n_bad++; $display("FAIL read_1234: got lat=%0d data=%h expected 65/a5", lat, rd); end
    endtask

    task automatic test_cache;
        int lat, exp_lat, falls0, exp_falls;
        logic ab;
        logic [7:0] rd;
        do_access(0, 1'b1, 16'h0042, 8'h7E, lat, ab, rd);
        n_cmp++; if (lat !== 65 || rd !== 8'hA5) begin
            n_bad++; $display("FAIL cache_wr: got lat=%0d data=%h expected 65/a5", lat, rd); end
        falls0 = g_inst[0].cs_falls;
`ifdef SPI_SRAM_CTRL_LAST_BYTE_CACHE_EN
        exp_lat   = 1;
        exp_falls = falls0;
`else
        exp_lat   = 65;
        exp_falls = falls0 + 1;
`endif
        do_access(0, 1'b0, 16'h0042, 8'h00, lat, ab, rd);
        n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL cache_rd_latency: got %0d expected %0d", lat, exp_lat); end
        n_cmp++; if (rd !== 8'h7E) begin n_bad++; $display("FAIL cache_rd_data: got %h expected 7e", rd); end
        n_cmp++; if (g_inst[0].cs_falls !== exp_falls) begin
            n_bad++; $display("FAIL cache_cs_activity: got %0d expected %0d", g_inst[0].cs_falls, exp_falls); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_clk_div3();
        test_reset_abort();
        test_cache();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
